// File: rtl/csi_pkg.sv
// ============================================================================
// csi_pkg : CSI-2 data types, header field widths and controller state encoding
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package csi_pkg;

  localparam int DT_W = 6;
  localparam int WC_W = 16;

  localparam logic [DT_W-1:0] CSI_DT_FS    = 6'h00;
  localparam logic [DT_W-1:0] CSI_DT_FE    = 6'h01;
  localparam logic [DT_W-1:0] CSI_DT_LS    = 6'h02;
  localparam logic [DT_W-1:0] CSI_DT_LE    = 6'h03;
  localparam logic [DT_W-1:0] CSI_DT_RAW8  = 6'h2A;
  localparam logic [DT_W-1:0] CSI_DT_RAW10 = 6'h2B;

  // Data types below this value are short packets (no payload, no CRC)
  localparam logic [DT_W-1:0] CSI_DT_SHORT_LIMIT = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR1    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_e;

  // RAW10 packs 4 pixels into 5 bytes; a line must hold whole beat pairs of groups
  function automatic logic raw10_wc_legal(input logic [WC_W-1:0] wc);
    return (wc != '0) && ((wc % 16'd10) == 16'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csi_packet_controller.sv
// ============================================================================
// csi_packet_controller : CSI-2 header parser and RAW10 payload gate for the decoder
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module csi_packet_controller
  import csi_pkg::*;
#(
  parameter logic [5:0] DT_RAW10        = CSI_DT_RAW10,
  parameter logic [5:0] DT_FS           = CSI_DT_FS,
  parameter logic [5:0] DT_FE           = CSI_DT_FE,
  parameter int         LINES_PER_FRAME = 480,
  parameter int         LINE_CNT_W      = 12
) (
  input  logic                  rxbyteclkhs,
  input  logic                  reset_n,
  input  logic [15:0]           data_in,
  input  logic                  data_in_valid,
  output logic [15:0]           data_out,
  output logic                  frame_valid,
  output logic                  frame_active,
  output logic                  last_packet,
  output logic [5:0]            data_type,
  output logic [15:0]           word_count,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  err_wc,
  output logic                  err_eot
);

  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [LINE_CNT_W-1:0] MAX_LINE  = LINE_CNT_W'(LINES_PER_FRAME);

  state_e                state_q, state_d;
  logic [5:0]            di_q, di_d;
  logic [7:0]            wc_lo_q, wc_lo_d;
  logic [5:0]            dt_q, dt_d;
  logic [15:0]           wc_q, wc_d;
  logic [14:0]           beat_q, beat_d;
  logic                  gate_q, gate_d;
  logic                  fv_q, fv_d;
  logic                  fa_q, fa_d;
  logic                  lp_q, lp_d;
  logic [LINE_CNT_W-1:0] lc_q, lc_d;
  logic                  errwc_q, errwc_d;
  logic                  erreot_q, erreot_d;
  logic [15:0]           dout_q;
  logic [15:0]           wc_full;

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      di_q     <= '0;
      wc_lo_q  <= '0;
      dt_q     <= '0;
      wc_q     <= '0;
      beat_q   <= '0;
      gate_q   <= 1'b0;
      fv_q     <= 1'b0;
      fa_q     <= 1'b0;
      lp_q     <= 1'b0;
      lc_q     <= '0;
      errwc_q  <= 1'b0;
      erreot_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      di_q     <= di_d;
      wc_lo_q  <= wc_lo_d;
      dt_q     <= dt_d;
      wc_q     <= wc_d;
      beat_q   <= beat_d;
      gate_q   <= gate_d;
      fv_q     <= fv_d;
      fa_q     <= fa_d;
      lp_q     <= lp_d;
      lc_q     <= lc_d;
      errwc_q  <= errwc_d;
      erreot_q <= erreot_d;
      dout_q   <= data_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    di_d     = di_q;
    wc_lo_d  = wc_lo_q;
    dt_d     = dt_q;
    wc_d     = wc_q;
    beat_d   = beat_q;
    gate_d   = gate_q;
    fv_d     = fv_q;
    lc_d     = lc_q;
    fa_d     = 1'b0;
    lp_d     = 1'b0;
    errwc_d  = 1'b0;
    erreot_d = 1'b0;
    wc_full  = {data_in[15:8], wc_lo_q};

    unique case (state_q)
      ST_IDLE: begin
        if (data_in_valid) begin
          di_d    = data_in[13:8];
          wc_lo_d = data_in[7:0];
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (data_in_valid) begin
          dt_d = di_q;
          wc_d = wc_full;
          if (di_q < CSI_DT_SHORT_LIMIT) begin
            state_d = ST_IDLE;
            if (di_q == DT_FS) begin
              fv_d = 1'b1;
              lc_d = '0;
            end else if (di_q == DT_FE) begin
              fv_d = 1'b0;
            end
          end else begin
            beat_d  = wc_full[15:1];
            // A zero-length long packet carries only its CRC beat
            state_d = (wc_full[15:1] == '0) ? ST_CRC : ST_PAYLOAD;
            gate_d  = (di_q == DT_RAW10) && fv_q && raw10_wc_legal(wc_full);
            errwc_d = (di_q == DT_RAW10) && !raw10_wc_legal(wc_full);
          end
        end else begin
          erreot_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (data_in_valid) begin
          fa_d   = gate_q;
          lp_d   = gate_q && (lc_q == LAST_LINE);
          beat_d = beat_q - 15'd1;
          if (beat_q == 15'd1) begin
            state_d = ST_CRC;
            if (gate_q && (lc_q < MAX_LINE)) begin
              lc_d = lc_q + 1'b1;
            end
          end
        end else begin
          erreot_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_CRC: begin
        erreot_d = !data_in_valid;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_out     = dout_q;
  assign frame_valid  = fv_q;
  assign frame_active = fa_q;
  assign last_packet  = lp_q;
  assign data_type    = dt_q;
  assign word_count   = wc_q;
  assign line_count   = lc_q;
  assign err_wc       = errwc_q;
  assign err_eot      = erreot_q;

endmodule

`default_nettype wire

// File: tb/tb_csi_packet_controller.sv
// ============================================================================
// tb_csi_packet_controller : vector table plus scoreboard bench for the CSI packet controller
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_csi_packet_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] din;

  logic [15:0] dout_a, dout_b;
  logic        fv_a, fa_a, lp_a, ewc_a, eeot_a;
  logic        fv_b, fa_b, lp_b, ewc_b, eeot_b;
  logic [5:0]  dt_a, dt_b;
  logic [15:0] wc_a, wc_b;
  logic [11:0] lc_a, lc_b;

  always #5 clk = ~clk;

  csi_packet_controller dut (
    .rxbyteclkhs(clk), .reset_n(rst_n), .data_in(din), .data_in_valid(valid),
    .data_out(dout_a), .frame_valid(fv_a), .frame_active(fa_a), .last_packet(lp_a),
    .data_type(dt_a), .word_count(wc_a), .line_count(lc_a), .err_wc(ewc_a), .err_eot(eeot_a)
  );

  csi_packet_controller #(.LINES_PER_FRAME(2)) dut2 (
    .rxbyteclkhs(clk), .reset_n(rst_n), .data_in(din), .data_in_valid(valid),
    .data_out(dout_b), .frame_valid(fv_b), .frame_active(fa_b), .last_packet(lp_b),
    .data_type(dt_b), .word_count(wc_b), .line_count(lc_b), .err_wc(ewc_b), .err_eot(eeot_b)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        fv;
    logic        fa;
    logic        lp;
    logic        lp2;
    logic        ewc;
    logic        eeot;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic fv, input logic fa,
                              input logic lp, input logic lp2, input logic ewc, input logic eeot);
    vec_t t;
    t.v = v; t.d = d; t.fv = fv; t.fa = fa; t.lp = lp; t.lp2 = lp2; t.ewc = ewc; t.eeot = eeot;
    return t;
  endfunction

  // Each beat's expectations refer to the outputs registered from that beat
  task automatic drive(input vec_t t);
    @(negedge clk);
    exp_q.push_back(t);
    valid = t.v;
    din   = t.d;
    @(posedge clk);
    #2;
  endtask

  always begin
    vec_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("frame_valid",  32'(fv_a),   32'(e.fv));
      chk("frame_active", 32'(fa_a),   32'(e.fa));
      chk("fa_lpf2",      32'(fa_b),   32'(e.fa));
      chk("last_packet",  32'(lp_a),   32'(e.lp));
      chk("last_lpf2",    32'(lp_b),   32'(e.lp2));
      chk("err_wc",       32'(ewc_a),  32'(e.ewc));
      chk("err_eot",      32'(eeot_a), 32'(e.eeot));
      chk("data_out",     32'(dout_a), 32'(e.d));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fv"},   32'(fv_a),   32'h0);
    chk({tag, "_fa"},   32'(fa_a),   32'h0);
    chk({tag, "_lp"},   32'(lp_a),   32'h0);
    chk({tag, "_dt"},   32'(dt_a),   32'h0);
    chk({tag, "_wc"},   32'(wc_a),   32'h0);
    chk({tag, "_lc"},   32'(lc_a),   32'h0);
    chk({tag, "_ewc"},  32'(ewc_a),  32'h0);
    chk({tag, "_eeot"}, 32'(eeot_a), 32'h0);
    chk({tag, "_dout"}, 32'(dout_a), 32'h0);
    chk({tag, "_fv2"},  32'(fv_b),   32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    din   = 16'h0000;

    // FS, one RAW10 line of WC=10, FE
    tbl[0]  = mk(0, 16'h5555, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 16'h0000, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 16'h2B0A, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 16'h005A, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 16'h1111, 1, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 16'h2222, 1, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 16'h3333, 1, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 16'h4444, 1, 1, 0, 0, 0, 0);
    tbl[9]  = mk(1, 16'h6666, 1, 1, 0, 0, 0, 0);
    tbl[10] = mk(1, 16'hCCCC, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 16'h0100, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 16'h0000, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) drive(tbl[i]);
    chk("t1_line_count", 32'(lc_a), 32'd1);
    chk("t1_data_type",  32'(dt_a), 32'h01);
    chk("t1_word_count", 32'(wc_a), 32'h0);

    // Two lines of WC=20; the 2-line instance flags only the second
    drive(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0));
    chk("t2_fs_clears_lc", 32'(lc_a), 32'd0);
    for (int ln = 0; ln < 2; ln++) begin
      drive(mk(1, 16'h2B14, 1, 0, 0, 0, 0, 0));
      drive(mk(1, 16'h0077, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 10; i++)
        drive(mk(1, 16'hA000 + 16'(ln * 16 + i), 1, 1, 0, (ln == 1), 0, 0));
      drive(mk(1, 16'hC0C0, 1, 0, 0, 0, 0, 0));
    end
    chk("t2_line_count",  32'(lc_a), 32'd2);
    chk("t2_line_count2", 32'(lc_b), 32'd2);

    // RAW10 with WC=12 is illegal: error pulse, packet consumed ungated
    drive(mk(1, 16'h2B0C, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0033, 1, 0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++) drive(mk(1, 16'hB000 + 16'(i), 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'hC1C1, 1, 0, 0, 0, 0, 0));
    chk("t3_word_count", 32'(wc_a), 32'd12);
    chk("t3_line_count", 32'(lc_a), 32'd2);

    // EoT on the third payload beat of a WC=20 line
    drive(mk(1, 16'h2B14, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0044, 1, 0, 0, 0, 0, 0));
    chk("t4_data_type",  32'(dt_a), 32'h2B);
    chk("t4_word_count", 32'(wc_a), 32'd20);
    drive(mk(1, 16'hD001, 1, 1, 0, 0, 0, 0));
    drive(mk(1, 16'hD002, 1, 1, 0, 0, 0, 0));
    drive(mk(0, 16'hD003, 1, 0, 0, 0, 0, 1));
    drive(mk(1, 16'h0100, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0));
    chk("t4_line_count", 32'(lc_a), 32'd2);
    chk("t4_fe_type",    32'(dt_a), 32'h01);

    // RAW8 long packet is consumed silently
    drive(mk(1, 16'h2A08, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0055, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) drive(mk(1, 16'hE000 + 16'(i), 0, 0, 0, 0, 0, 0));
    drive(mk(1, 16'hC2C2, 0, 0, 0, 0, 0, 0));
    chk("t5_data_type",  32'(dt_a), 32'h2A);
    chk("t5_word_count", 32'(wc_a), 32'd8);

    // Reset in the middle of a payload
    drive(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h2B0A, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0066, 1, 0, 0, 0, 0, 0));
    drive(mk(1, 16'hF001, 1, 1, 0, 0, 0, 0));
    drive(mk(1, 16'hF002, 1, 1, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    din   = 16'h0000;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 16'h0000, 1, 0, 0, 0, 0, 0));
    chk("t6_line_count", 32'(lc_a), 32'd0);
    chk("t6_data_type",  32'(dt_a), 32'h00);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
